// File: rtl/ifq_pkg.sv
// Shared constants, entry layout and write-count helper for the fetch instruction queue.
package ifq_pkg;
  localparam int IFQ_DEPTH   = 16;
  localparam int IFQ_IN_W    = 10;
  localparam int IFQ_OUT_W   = 2;
  localparam int IFQ_ENTRY_W = 64;
  localparam int PC_LSB      = 32;
  localparam int INST_LSB    = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  // Entries kept from a bundle: up to and including the first taken jump, never more than IN_W.
  function automatic logic [4:0] ifq_write_count(input logic       cut_valid,
                                                 input logic [7:0] cut,
                                                 input logic [3:0] number);
    logic [5:0] n;
    logic [5:0] lim;
    n   = {2'b00, number};
    lim = {1'b0, cut[4:0]} + 6'd1;
    if (cut_valid && (lim < n)) n = lim;
    if (n > 6'(IFQ_IN_W)) n = 6'(IFQ_IN_W);
    return n[4:0];
  endfunction
endpackage

// File: rtl/fetch_inst_queue_if.sv
// Enqueue/dequeue handshake bundle between the jump-cut stage, the queue and decode.
interface fetch_inst_queue_if #(
  parameter int DEPTH   = 16,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 2,
  parameter int ENTRY_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     i_flush;
  logic                     i_enqValid;
  logic                     o_enqReady;
  logic [3:0]               i_alignedInstructionNumber_4;
  logic [7:0]               i_cutPosition_8;
  logic                     i_cutValid;
  logic [IN_W*ENTRY_W-1:0]  i_alignedInstructionTableBus_640;
  logic [OUT_W-1:0]         o_deqValid_2;
  logic [OUT_W*ENTRY_W-1:0] o_deqBus_128;
  logic                     i_deqReady;
  logic [CW-1:0]            o_count_5;
  logic [31:0]              o_enqStall_32;
  logic [31:0]              o_emptyCycles_32;

  modport master (
    output i_flush, i_enqValid, i_alignedInstructionNumber_4, i_cutPosition_8,
           i_cutValid, i_alignedInstructionTableBus_640, i_deqReady,
    input  o_enqReady, o_deqValid_2, o_deqBus_128, o_count_5, o_enqStall_32, o_emptyCycles_32
  );

  modport slave (
    input  i_flush, i_enqValid, i_alignedInstructionNumber_4, i_cutPosition_8,
           i_cutValid, i_alignedInstructionTableBus_640, i_deqReady,
    output o_enqReady, o_deqValid_2, o_deqBus_128, o_count_5, o_enqStall_32, o_emptyCycles_32
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x ENTRY_W register file: one IN_W-wide wrapping masked write, OUT_W combinational reads.
module fetch_queue_mem #(
  parameter int DEPTH   = 16,
  parameter int IN_W    = 10,
  parameter int OUT_W   = 2,
  parameter int ENTRY_W = 64,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1,
  localparam int IW     = $clog2(IN_W)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            base,
  input  logic [CW-1:0]            n,
  input  logic [IN_W*ENTRY_W-1:0]  wdata,
  input  logic [AW-1:0]            head,
  output logic [OUT_W*ENTRY_W-1:0] rdata
);
  logic [DEPTH-1:0][ENTRY_W-1:0] mem;
  logic [IN_W-1:0][ENTRY_W-1:0]  wvec;

  assign wvec = wdata;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0]      off;
    logic [IW-1:0]      sel;
    logic               hit;
    logic [ENTRY_W-1:0] q;

    // Distance of this slot past the write base decides which bundle lane lands here.
    assign off = AW'(i) - base;
    assign sel = (CW'(off) < CW'(IN_W)) ? IW'(off) : '0;
    assign hit = we && (CW'(off) < n);

    always_ff @(posedge clk)
      if (hit) q <= wvec[sel];

    assign mem[i] = q;
  end

  for (genvar j = 0; j < OUT_W; j++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx = head + AW'(j);
    assign rdata[j*ENTRY_W +: ENTRY_W] = mem[idx];
  end
endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch instruction queue: jump-trimmed bundles in, up to OUT_W entries per cycle out to decode.
// Define IFQ_PERF_EN to build the enqueue-stall and empty-cycle performance counters.
module fetch_inst_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH,
  parameter int IN_W    = IFQ_IN_W,
  parameter int OUT_W   = IFQ_OUT_W,
  parameter int ENTRY_W = IFQ_ENTRY_W
) (
  input logic               clk,
  input logic               rst,
  fetch_inst_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          enq_ready;
  logic          enq_fire;
  logic [4:0]    wc;
  logic [CW-1:0] n, n_eff;
  logic [CW-1:0] deq_avail, d_eff;

  assign enq_ready = (CW'(DEPTH) - count) >= CW'(IN_W);
  assign enq_fire  = bus.i_enqValid && enq_ready;

  assign wc    = ifq_write_count(bus.i_cutValid, bus.i_cutPosition_8, bus.i_alignedInstructionNumber_4);
  assign n     = (CW'(wc) > CW'(IN_W)) ? CW'(IN_W) : CW'(wc);
  assign n_eff = enq_fire ? n : '0;

  // Valid slots are a thermometer of occupancy, so a dequeue takes min(count, OUT_W).
  assign deq_avail = (count >= CW'(OUT_W)) ? CW'(OUT_W) : count;
  assign d_eff     = bus.i_deqReady ? deq_avail : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(d_eff);
      tail  <= tail + AW'(n_eff);
      count <= count + n_eff - d_eff;
    end
  end

  fetch_queue_mem #(
    .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .ENTRY_W(ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire && !bus.i_flush),
    .base  (tail),
    .n     (n),
    .wdata (bus.i_alignedInstructionTableBus_640),
    .head  (head),
    .rdata (bus.o_deqBus_128)
  );

  for (genvar j = 0; j < OUT_W; j++) begin : g_vld
    assign bus.o_deqValid_2[j] = count > CW'(j);
  end

  assign bus.o_enqReady = enq_ready;
  assign bus.o_count_5  = count;

`ifdef IFQ_PERF_EN
  logic [31:0] stall_q, empty_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      empty_q <= '0;
    end else begin
      if (bus.i_enqValid && !enq_ready) stall_q <= stall_q + 32'd1;
      if (count == '0)                  empty_q <= empty_q + 32'd1;
    end
  end

  assign bus.o_enqStall_32    = stall_q;
  assign bus.o_emptyCycles_32 = empty_q;
`else
  assign bus.o_enqStall_32    = '0;
  assign bus.o_emptyCycles_32 = '0;
`endif
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Scoreboard bench: stimulus pushes accepted entries, a negedge monitor pops and compares.
module tb_fetch_inst_queue;
  import ifq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_inst_queue_if #(.DEPTH(16), .IN_W(10), .OUT_W(2), .ENTRY_W(64)) bus ();

  fetch_inst_queue #(.DEPTH(16), .IN_W(10), .OUT_W(2), .ENTRY_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_empty = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: state seen at a negedge reflects every input applied up to the previous posedge.
  initial begin
    int          sz;
    int          take;
    logic [1:0]  ev;
    logic [31:0] es, ee;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_stall = '0;
        exp_empty = '0;
        chk("rst_count", 64'(bus.o_count_5), 64'd0);
        chk("rst_deq_valid", 64'(bus.o_deqValid_2), 64'd0);
        chk("rst_enq_ready", 64'(bus.o_enqReady), 64'd1);
        chk("rst_enq_stall", 64'(bus.o_enqStall_32), 64'd0);
        chk("rst_empty_cycles", 64'(bus.o_emptyCycles_32), 64'd0);
      end else begin
        sz = sb.size();
        ev = (sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00;
        chk("count", 64'(bus.o_count_5), 64'(sz));
        chk("enq_ready", 64'(bus.o_enqReady), 64'((16 - sz) >= 10));
        chk("deq_valid", 64'(bus.o_deqValid_2), 64'(ev));
        for (int j = 0; j < 2; j++)
          if (j < sz) chk($sformatf("slot%0d", j), bus.o_deqBus_128[j*64 +: 64], sb[j]);
`ifdef IFQ_PERF_EN
        es = exp_stall;
        ee = exp_empty;
`else
        es = '0;
        ee = '0;
`endif
        chk("enq_stall", 64'(bus.o_enqStall_32), 64'(es));
        chk("empty_cycles", 64'(bus.o_emptyCycles_32), 64'(ee));
        if (bus.i_enqValid && !((16 - sz) >= 10)) exp_stall = exp_stall + 32'd1;
        if (sz == 0) exp_empty = exp_empty + 32'd1;
        if (bus.i_deqReady && !bus.i_flush) begin
          take = (sz < 2) ? sz : 2;
          repeat (take) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic set_idle();
    bus.i_flush                      = 1'b0;
    bus.i_enqValid                   = 1'b0;
    bus.i_alignedInstructionNumber_4 = '0;
    bus.i_cutPosition_8              = '0;
    bus.i_cutValid                   = 1'b0;
    bus.i_deqReady                   = 1'b0;
    bus.i_alignedInstructionTableBus_640 = '0;
  endtask

  task automatic cycle(input bit v, input int num, input bit cv, input int cut,
                       input bit dr, input bit fl);
    logic [63:0] ent[10];
    int          sz;
    int          n;
    bit          acc;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      ent[k] = {$urandom(), $urandom()};
      bus.i_alignedInstructionTableBus_640[k*64 +: 64] = ent[k];
    end
    bus.i_enqValid                   = v;
    bus.i_alignedInstructionNumber_4 = num[3:0];
    bus.i_cutValid                   = cv;
    bus.i_cutPosition_8              = cut[7:0];
    bus.i_deqReady                   = dr;
    bus.i_flush                      = fl;
    sz  = sb.size();
    acc = v && ((16 - sz) >= 10);
    n   = num % 16;
    if (cv && ((cut % 32) + 1) < n) n = (cut % 32) + 1;
    if (n > 10) n = 10;
    @(negedge clk); #1;
    if (fl) sb.delete();
    else if (acc) for (int k = 0; k < n; k++) sb.push_back(ent[k]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_idle();
    rst = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    set_idle();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) cycle(0, 0, 0, 0, 0, 0);

    // 8 uncut entries, then a refused second bundle, then drain.
    cycle(1, 8, 0, 0, 0, 0);
    cycle(1, 8, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 1, 0);

    // Cut at 2 keeps 3 entries: drain 2, then 1, then empty.
    cycle(1, 8, 1, 2, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 1, 0);

    // Walk pointers to 14, then a 6-entry bundle wraps.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 7, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 7, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 6, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);

    // Enqueue 4 while dequeuing 2 at count 2, then flush races an enqueue.
    cycle(1, 2, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 1, 0);
    cycle(1, 8, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Stall counting at count 8, then reset mid-operation.
    cycle(1, 8, 0, 0, 0, 0);
    repeat (5) cycle(1, 3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (2) cycle(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 255), $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end

    @(posedge clk); #1;
    set_idle();
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Instruction fetch queue directly downstream of the non-branch-jump processing stage. Each accepted fetch bundle is trimmed at that stage's cut position (the first taken jump, inclusive), and the surviving {pc, inst} entries are appended to a circular buffer. Decode drains the buffer up to two entries per cycle. A flush from the backend discards all queued entries when a mispredict redirects the PC.

## Interface
Parameters:
- DEPTH, 16: queue entries; power of two, at least IN_W.
- IN_W, 10: entries per input bundle.
- OUT_W, 2: entries presented to decode per cycle.
- ENTRY_W, 64: entry width; pc in [63:32], inst in [31:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_flush  in  1  synchronous discard of all queue contents.
- i_enqValid  in  1  bundle valid.
- o_enqReady  out  1  queue can accept a full bundle.
- i_alignedInstructionNumber_4  in  4  number of valid entries in the bundle.
- i_cutPosition_8  in  8  index of the first jump entry; bits [4:0] are used.
- i_cutValid  in  1  bundle contains a jump, so the cut applies.
- i_alignedInstructionTableBus_640  in  IN_W*ENTRY_W  bundle; entry k is at [k*64 +: 64].
- o_deqValid_2  out  OUT_W  thermometer-coded; bit j means slot j is valid.
- o_deqBus_128  out  OUT_W*ENTRY_W  slot j holds the entry at head+j.
- i_deqReady  in  1  decode consumes every valid slot this cycle.
- o_count_5  out  log2(DEPTH)+1  occupancy.
- o_enqStall_32  out  32  performance counter (see Configuration).
- o_emptyCycles_32  out  32  performance counter (see Configuration).

## Operation
- State: head and tail pointers (log2(DEPTH) bits each, wrapping modulo DEPTH) and a count register.
- o_enqReady = (DEPTH - count) >= IN_W. It depends only on state, never on input data.
- Enqueue fires on i_enqValid && o_enqReady.
- Write count n:
  - If i_cutValid: n = min(cut[4:0]+1, number).
  - Otherwise: n = number.
  - n is then clamped to IN_W.
- On enqueue, bundle entries 0..n-1 are written to tail..tail+n-1 with wrap-around, and tail advances by n.
- n = 0 completes the handshake with no state change.
- Output slots: o_deqValid_2[j] = (count > j). o_deqBus_128 slot j shows mem[head+j], wrapping. Slot data is undefined when its valid bit is clear.
- Dequeue: when i_deqReady, d = popcount(o_deqValid_2) and head advances by d.
- Simultaneous enqueue and dequeue: count_next = count + n - d.
- Flush has priority over everything:
  - head, tail and count become 0.
  - Any enqueue or dequeue in the same cycle is discarded.
  - Storage contents are not cleared.

## Timing
- Reset values: head = tail = count = 0; o_deqValid_2 = 0; o_enqReady = 1; o_count_5 = 0; both perf counters 0.
- Reset mid-operation aborts immediately and returns the block to the reset values.
- Enqueue-to-output latency is 1 cycle: an entry written at edge t appears on the output slots after edge t. There is no same-cycle bypass.
- o_enqReady and o_deqValid_2 are functions of registered state only.
- A full queue (count = DEPTH) holds o_enqReady = 0.
- An empty queue holds o_deqValid_2 = 0; i_deqReady is then a no-op.

## Configuration
- IFQ_PERF_EN defined:
  - o_enqStall_32 increments each cycle with i_enqValid && !o_enqReady.
  - o_emptyCycles_32 increments each cycle with count == 0.
  - Both counters wrap at 2^32 and are not cleared by flush.
- IFQ_PERF_EN undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Package ifq_pkg holds:
  - IFQ_DEPTH, IFQ_IN_W, IFQ_OUT_W, IFQ_ENTRY_W.
  - PC_LSB = 32 and INST_LSB = 0.
  - Function ifq_write_count(cutValid, cut, number), which returns the clamped n.
- One sub-module, fetch_queue_mem:
  - DEPTH x ENTRY_W register storage.
  - IN_W-wide masked write port at a base index with wrap.
  - OUT_W combinational read ports at head+j.
- Pointer and count logic and the handshakes stay in fetch_inst_queue.

## Test plan
- Reset then idle: o_enqReady = 1, o_deqValid_2 = 0, o_count_5 = 0.
- Bundle with number = 8, cutValid = 0, i_deqReady = 0. Next cycle count = 8 and slot 0 pc equals entry 0 pc. A second bundle is refused (o_enqReady = 0, since 16 - 8 < 10).
- Bundle with number = 8, cutValid = 1, cut = 2. Count becomes 3. Draining with i_deqReady = 1 gives 2 entries, then 1 entry (o_deqValid_2 = 01), then empty.
- Wrap-around: bring head and tail to 14, then enqueue 6 entries. Entries land in slots 14, 15, 0, 1, 2, 3, and dequeue order matches the bundle order.
- Simultaneous enqueue of 4 and dequeue of 2 at count = 2: next count = 4. Then assert i_flush together with an enqueue: next count = 0, o_deqValid_2 = 0, and the enqueued data is absent.
- With IFQ_PERF_EN: hold i_enqValid for 5 cycles while count = 8 → o_enqStall_32 = 5. Without IFQ_PERF_EN → reads 0.
